alu_multicycle: RTL and testbench

//  Parametrised successor ALU: WIDTH-bit datapath, registered result and SREG (ITHSVNZC).
//  All ops except MUL complete in one cycle. MUL is iterative shift-add and gives a 2*WIDTH product.

---
 rtl/alu_multicycle.sv | 166 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops with an
// ITHSVNZC status register, plus an iterative shift-add multiplier.
module alu_multicycle #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             use_carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sreg_we,
  input  logic [7:0]       sreg_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_hi,
  output logic [7:0]       sreg
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_LSL = 3'd3;
  localparam logic [2:0] OP_LSR = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t state, state_nx;

  logic [2*WIDTH-1:0] mcand, acc, acc_add;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic             accept, mul_last, cin;
  logic [WIDTH:0]   ax, bx, cx, ext;
  logic [WIDTH-1:0] r;
  logic [7:0]       fl;

  assign busy     = (state == S_MUL);
  assign accept   = start && (state == S_IDLE);
  assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
  assign acc_add  = acc + (mplier[0] ? mcand : '0);

  assign cin = use_carry & sreg[0];
  assign ax  = {1'b0, a};
  assign bx  = {1'b0, b};
  assign cx  = {{WIDTH{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept && op == OP_MUL) state_nx = S_MUL;
      S_MUL:  if (mul_last) state_nx = S_IDLE;
    endcase
  end

  // Half carry/borrow at bit 4 recovered as a4 ^ b4 ^ sum4.
  always_comb begin
    r   = '0;
    fl  = sreg;
    ext = '0;
    unique case (op)
      OP_ADD: begin
        ext   = ax + bx + cx;
        r     = ext[M:0];
        fl[0] = ext[WIDTH];
        fl[5] = ax[4] ^ bx[4] ^ ext[4];
        fl[3] = (a[M] == b[M]) && (r[M] != a[M]);
      end
      OP_SUB: begin
        ext   = ax - bx - cx;
        r     = ext[M:0];
        fl[0] = ext[WIDTH];
        fl[5] = ax[4] ^ bx[4] ^ ext[4];
        fl[3] = (a[M] != b[M]) && (r[M] != a[M]);
      end
      OP_MUL: ;
      OP_LSL: begin
        r     = {a[M-1:0], cin};
        fl[0] = a[M];
        fl[5] = a[3];
        fl[3] = r[M] ^ a[M];
      end
      OP_LSR: begin
        r     = {cin, a[M:1]};
        fl[0] = a[0];
        fl[3] = r[M] ^ a[0];
      end
      OP_AND: begin
        r     = a & b;
        fl[3] = 1'b0;
      end
      OP_OR: begin
        r     = a | b;
        fl[3] = 1'b0;
      end
      OP_XOR: begin
        r     = a ^ b;
        fl[3] = 1'b0;
      end
    endcase
    if (op != OP_MUL) begin
      fl[2] = r[M];
      fl[4] = r[M] ^ fl[3];
      fl[1] = (r == '0) &&
              !(op == OP_SUB && use_carry && !sreg[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      q_hi   <= '0;
      sreg   <= '0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          q    <= r;
          q_hi <= '0;
          sreg <= fl;
          done <= 1'b1;
        end
      end else if (state == S_MUL) begin
        acc    <= acc_add;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          {q_hi, q} <= acc_add;
          sreg      <= {sreg[7:2], acc_add == '0, acc_add[2*WIDTH-1]};
          done      <= 1'b1;
        end
      end
      // A direct write overrides any flags produced at the same edge.
      if (sreg_we) sreg <= sreg_wdata;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int W    = 8;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic         use_carry = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sreg_we = 1'b0;
  logic [7:0]   sreg_wdata = '0;
  logic         busy, done;
  logic [W-1:0] q, q_hi;
  logic [7:0]   sreg;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .use_carry(use_carry), .a(a), .b(b),
    .sreg_we(sreg_we), .sreg_wdata(sreg_wdata),
    .busy(busy), .done(done), .q(q), .q_hi(q_hi), .sreg(sreg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int qh;
    int sr;
    int tag;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] msreg = '0;

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic push_exp(input int eq, input int eqh, input int esr,
                          input int tag);
    exp_t e;
    e.q = eq; e.qh = eqh; e.sr = esr; e.tag = tag;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no result");
      end else begin
        mon_e = sbq.pop_front();
        chk($sformatf("q#%0d", mon_e.tag), int'(q), mon_e.q);
        chk($sformatf("q_hi#%0d", mon_e.tag), int'(q_hi), mon_e.qh);
        chk($sformatf("sreg#%0d", mon_e.tag), int'(sreg), mon_e.sr);
      end
    end
  end

  function automatic void ref_op(input int o, input bit uc,
                                 input int av, input int bv,
                                 input logic [7:0] s,
                                 output int r, output int rh,
                                 output logic [7:0] ns);
    int cin, sa, sbv, x, sx;
    bit c, h, v, n, z;
    cin = (uc && s[0]) ? 1 : 0;
    sa  = (av >= HALF) ? av - FULL : av;
    sbv = (bv >= HALF) ? bv - FULL : bv;
    c = s[0]; h = s[5]; v = 1'b0; r = 0; rh = 0; ns = s;
    case (o)
      0: begin
        x  = av + bv + cin;
        sx = sa + sbv + cin;
        r  = x % FULL;
        c  = x >= FULL;
        h  = ((av % 16) + (bv % 16) + cin) >= 16;
        v  = (sx >= HALF) || (sx < -HALF);
      end
      1: begin
        x  = av - bv - cin;
        sx = sa - sbv - cin;
        r  = (x + FULL) % FULL;
        c  = x < 0;
        h  = ((av % 16) - (bv % 16) - cin) < 0;
        v  = (sx >= HALF) || (sx < -HALF);
      end
      2: begin
        x     = av * bv;
        r     = x % FULL;
        rh    = x / FULL;
        ns[0] = x >= FULL * HALF;
        ns[1] = x == 0;
        return;
      end
      3: begin
        r = (av * 2 + cin) % FULL;
        c = av >= HALF;
        h = ((av / 8) % 2) == 1;
        v = (r >= HALF) != c;
      end
      4: begin
        r = av / 2 + cin * HALF;
        c = (av % 2) == 1;
        v = (r >= HALF) != c;
      end
      5: r = av & bv;
      6: r = av | bv;
      default: r = av ^ bv;
    endcase
    n = r >= HALF;
    z = r == 0;
    if (o == 1 && uc && !s[1]) z = 1'b0;
    ns = {s[7:6], h, n ^ v, v, n, z, c};
  endfunction

  task automatic drive(input int o, input bit uc, input int av,
                       input int bv, input bit we, input logic [7:0] wd,
                       input bit mwe, input logic [7:0] mwd);
    int k;
    start = 1'b1; op = 3'(o); use_carry = uc;
    a = W'(av); b = W'(bv);
    sreg_we = we; sreg_wdata = wd;
    @(negedge clk);
    start = 1'b0; sreg_we = 1'b0;
    if (o == 2) begin
      k = 0;
      if (mwe) begin
        sreg_we = 1'b1; sreg_wdata = mwd;
      end
      while (busy && k < 3 * W) begin
        start = 1'($urandom); op = 3'($urandom);
        use_carry = 1'($urandom);
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        sreg_we = 1'b0;
        k++;
      end
      start = 1'b0;
      chk("mul_busy_cycles", k, W);
    end
  endtask

  task automatic issue(input int o, input bit uc, input int av,
                       input int bv, input bit we, input logic [7:0] wd,
                       input bit mwe, input logic [7:0] mwd,
                       input int tag);
    int r, rh;
    logic [7:0] base, ns;
    if (o == 2) begin
      base = mwe ? mwd : (we ? wd : msreg);
      ref_op(o, uc, av, bv, base, r, rh, ns);
    end else begin
      ref_op(o, uc, av, bv, msreg, r, rh, ns);
      if (we) ns = wd;
    end
    push_exp(r, rh, int'(ns), tag);
    msreg = ns;
    drive(o, uc, av, bv, we, wd, mwe, mwd);
  endtask

  task automatic dir(input int o, input bit uc, input int av,
                     input int bv, input int eq, input int eqh,
                     input int esr, input int tag);
    push_exp(eq, eqh, esr, tag);
    msreg = 8'(esr);
    drive(o, uc, av, bv, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic set_sreg(input logic [7:0] v);
    sreg_we = 1'b1; sreg_wdata = v;
    @(negedge clk);
    sreg_we = 1'b0;
    msreg = v;
    chk("sreg_write", int'(sreg), int'(v));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int o, av, bv;
    bit uc, we, mwe;
    logic [7:0] wd, mwd;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_q_hi", int'(q_hi), 0);
    chk("rst_sreg", int'(sreg), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;

    set_sreg(8'h00);
    dir(0, 1'b0, 'h7F, 'h01, 'h80, 0, 'h2C, 1);
    set_sreg(8'h01);
    dir(0, 1'b1, 'hFF, 'h00, 'h00, 0, 'h23, 2);
    set_sreg(8'h01);
    dir(1, 1'b1, 'h01, 'h00, 'h00, 0, 'h00, 3);
    set_sreg(8'h03);
    dir(1, 1'b1, 'h01, 'h00, 'h00, 0, 'h02, 4);

    // MUL 0xFF*0xFF with a stray start while busy
    set_sreg(8'h00);
    push_exp('h01, 'hFE, 'h01, 5);
    msreg = 8'h01;
    start = 1'b1; op = 3'd2; use_carry = 1'b0; a = 'hFF; b = 'hFF;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= W + 2; k++) begin
      chk($sformatf("busy_t%0d", k), int'(busy), int'(k <= W));
      chk($sformatf("done_t%0d", k), int'(done), int'(k == W + 1));
      if (k == 3) begin
        start = 1'b1; op = 3'd0; a = 'h11; b = 'h22;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end

    set_sreg(8'h01);
    dir(4, 1'b1, 'h02, 'h00, 'h81, 0, 'h0C, 6);
    dir(3, 1'b0, 'h80, 'h00, 'h00, 0, 'h1B, 7);

    push_exp('h30, 0, 'h80, 8);
    msreg = 8'h80;
    drive(5, 1'b0, 'hF0, 'h3C, 1'b1, 8'h80, 1'b0, 8'h00);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) set_sreg(8'($urandom));
      o   = $urandom_range(7);
      uc  = 1'($urandom);
      av  = $urandom_range(FULL - 1);
      bv  = $urandom_range(FULL - 1);
      we  = $urandom_range(7) == 0;
      wd  = 8'($urandom);
      mwe = $urandom_range(3) == 0;
      mwd = 8'($urandom);
      issue(o, uc, av, bv, we, wd, mwe, mwd, 100 + i);
      if ($urandom_range(3) == 0) @(negedge clk);
    end

    // Reset in the middle of a MUL
    set_sreg(8'h00);
    dir(2, 1'b0, 'hFF, 'hFF, 'h01, 'hFE, 'h01, 9);
    start = 1'b1; op = 3'd2; a = 'hC3; b = 'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_q", int'(q), 0);
    chk("mrst_q_hi", int'(q_hi), 0);
    chk("mrst_sreg", int'(sreg), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    msreg = 8'h00;
    repeat (12) @(negedge clk);

    chk("pending_results", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
